cosbus_master: RTL

COSBUS_MASTER -- requirements
Module: cosbus_master

---
 rtl/cosbus_master.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/cosbus_master.sv
// Bus-cycle sequencer: runs one P0..P7 read/write cycle per host request, paced by the asynchronous xclk.
// Optional COSBUS_TIMEOUT_EN: aborts a cycle after WAIT_LIMIT consecutive nwait-stretched periods.
module cosbus_master #(
  parameter int SYNC_STAGES = 2,
  parameter int WAIT_LIMIT  = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        xclk,
  input  logic        nwait,
  input  logic        clr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        tpa,
  output logic        tpb,
  output logic        nmrd,
  output logic        nmwr,
  output logic [7:0]  ma,
  output logic [7:0]  db_oe,
  output logic [7:0]  db_do,
  input  logic [7:0]  db_di
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

  logic [SYNC_STAGES-1:0] xclk_sync, nwait_sync, clr_sync;
  logic                   xclk_q;
  logic                   xclk_s, nwait_s, clr_s, x_rise, x_fall;

  // nwait/clr synchronizers clear to their inactive (high) level so reset does not look like a bus clear.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      xclk_sync  <= '0;
      nwait_sync <= '1;
      clr_sync   <= '1;
      xclk_q     <= 1'b0;
    end else begin
      xclk_sync  <= {xclk_sync[SYNC_STAGES-2:0], xclk};
      nwait_sync <= {nwait_sync[SYNC_STAGES-2:0], nwait};
      clr_sync   <= {clr_sync[SYNC_STAGES-2:0], clr};
      xclk_q     <= xclk_sync[SYNC_STAGES-1];
    end
  end

  assign xclk_s  = xclk_sync[SYNC_STAGES-1];
  assign nwait_s = nwait_sync[SYNC_STAGES-1];
  assign clr_s   = clr_sync[SYNC_STAGES-1];
  assign x_rise  = xclk_s & ~xclk_q;
  assign x_fall  = ~xclk_s & xclk_q;

  state_t      state;
  logic [2:0]  phase;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic        write_q;
  logic [7:0]  rdata_q;
  logic        timeout;

`ifdef COSBUS_TIMEOUT_EN
  localparam logic [7:0] STRETCH_LAST = 8'(WAIT_LIMIT - 1);
  logic [7:0] stretch_cnt;

  assign timeout = (state == S_RUN) && x_rise && !nwait_s && (stretch_cnt == STRETCH_LAST);

  always_ff @(posedge clk) begin
    if (!resetn || state != S_RUN) stretch_cnt <= '0;
    else if (x_rise)               stretch_cnt <= nwait_s ? 8'd0 : stretch_cnt + 8'd1;
  end
`else
  assign timeout = 1'b0;
`endif

  // Outputs for the period about to be entered (P0 from ARM, P+1 from RUN).
  logic [2:0] nxt_phase;
  logic [7:0] nxt_ma;
  logic       nxt_tpa, nxt_tpb, nxt_nmrd, nxt_nmwr, nxt_drive;

  always_comb begin
    nxt_phase = (state == S_RUN) ? phase + 3'd1 : 3'd0;
    nxt_ma    = (nxt_phase <= 3'd1) ? addr_q[15:8] : addr_q[7:0];
    nxt_tpa   = (nxt_phase == 3'd1);
    nxt_tpb   = (nxt_phase == 3'd6);
    nxt_nmrd  = write_q | (nxt_phase == 3'd0);
    nxt_nmwr  = ~(write_q && nxt_phase >= 3'd4 && nxt_phase <= 3'd6);
    nxt_drive = write_q && nxt_phase >= 3'd2;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      phase     <= 3'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      rdata_q   <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      tpa       <= 1'b0;
      tpb       <= 1'b0;
      nmrd      <= 1'b1;
      nmwr      <= 1'b1;
      ma        <= '0;
      db_oe     <= '0;
      db_do     <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      if (!clr_s || timeout) begin
        if (state == S_ARM || state == S_RUN) begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
        end
        state     <= S_IDLE;
        phase     <= 3'd0;
        req_ready <= 1'b0;
        tpa       <= 1'b0;
        tpb       <= 1'b0;
        nmrd      <= 1'b1;
        nmwr      <= 1'b1;
        ma        <= '0;
        db_oe     <= '0;
        db_do     <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            req_ready <= 1'b1;
            if (req_valid && req_ready) begin
              addr_q    <= req_addr;
              wdata_q   <= req_wdata;
              write_q   <= req_write;
              req_ready <= 1'b0;
              state     <= S_ARM;
            end
          end
          S_ARM, S_RUN: begin
            if (state == S_RUN && x_fall && phase == 3'd6 && !write_q)
              rdata_q <= db_di;
            if (x_rise && (state == S_ARM || nwait_s)) begin
              if (state == S_RUN && phase == 3'd7) begin
                state     <= S_DONE;
                rsp_valid <= 1'b1;
                if (!write_q) rsp_rdata <= rdata_q;
                tpa   <= 1'b0;
                tpb   <= 1'b0;
                nmrd  <= 1'b1;
                nmwr  <= 1'b1;
                ma    <= '0;
                db_oe <= '0;
                db_do <= '0;
              end else begin
                state <= S_RUN;
                phase <= nxt_phase;
                ma    <= nxt_ma;
                tpa   <= nxt_tpa;
                tpb   <= nxt_tpb;
                nmrd  <= nxt_nmrd;
                nmwr  <= nxt_nmwr;
                db_oe <= nxt_drive ? 8'hFF : 8'h00;
                db_do <= nxt_drive ? wdata_q : 8'h00;
              end
            end
          end
          S_DONE: begin
            state     <= S_IDLE;
            phase     <= 3'd0;
            req_ready <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
